fb_store: RTL and testbench
===========================

Name: fb_store

Overview:
- Pixel framebuffer that sits directly upstream of the SPI LCD stage.
- Holds a 60x32 array of 4-bit colour indices. The CPU side writes it; the LCD stage reads it asynchronously via x/y and converts each index to RGB565.
- Adds a bulk-clear sequencer and generates the single-cycle update pulse that starts an LCD frame transfer.

Parameters:
- FB_W, 60, columns (x range 0..FB_W-1).
- FB_H, 32, rows (y range 0..FB_H-1).
- COLOR_W, 4, bits per entry (colour index).
- REFRESH_CYCLES, 600000, minimum clk cycles between update pulses. Must exceed one LCD frame (32400 px x 17 cycles = 550800).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_x  in  6  write column.
- wr_y  in  6  write row.
- wr_color  in  4  write data.
- wr_ready  out  1  high when writes are accepted.
- clr_req  in  1  pulse; fill the whole buffer with clr_color.
- clr_color  in  4  fill value, sampled with clr_req.
- present  in  1  pulse; request a refresh.
- rd_x  in  6  LCD read column.
- rd_y  in  6  LCD read row.
- rd_color  out  4  asynchronous read data.
- update  out  1  single-cycle pulse to the LCD stage.
- busy  out  1  high while clear is running.
- drop_err  out  1  sticky; a write was dropped.

Behaviour:
- Storage:
  - FB_W*FB_H entries, linear address y*FB_W+x, 11 bits.
  - Contents after reset are undefined; reset does not touch the memory.
- Read path:
  - rd_color is combinational from rd_x/rd_y, valid in the same cycle. The LCD stage samples it the cycle after updating x/y.
  - Out-of-range rd_x/rd_y returns 0.
- Write path:
  - wr_ready = ~busy.
  - A write lands at posedge when wr_en & wr_ready & wr_x<FB_W & wr_y<FB_H. It is visible on rd_color the next cycle.
  - wr_en with busy=1, or with an out-of-range coordinate, is dropped and sets drop_err. drop_err clears only on rst.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR on clr_req: latch clr_color, clear_addr<=0, busy<=1.
  - CLEAR: write the latched colour at clear_addr each cycle, then increment.
  - At address FB_W*FB_H-1: write, return to IDLE, busy<=0, set dirty. The clear takes exactly 1920 cycles.
  - clr_req during CLEAR is ignored; the sweep is not restarted.
  - A wr_en in the same cycle as clr_req (IDLE) is accepted, then overwritten by the sweep.
- Dirty/pending:
  - dirty is set by any accepted write or a completed clear.
  - present sets pend.
- Refresh timer:
  - 20-bit count, saturates at REFRESH_CYCLES.
- Update pulse:
  - update=1 for one cycle when busy=0, timer saturated, and (pend, or dirty with auto-refresh).
  - Same edge: timer<=0, pend<=0, dirty<=0.
  - A write in the same cycle as update re-sets dirty (set wins).
  - present or clr_req during CLEAR is held pending until busy falls. No update is ever issued mid-clear.
- Reset values: update=0, busy=0, drop_err=0, wr_ready=1, dirty=0, pend=0, state=IDLE.
  - Timer resets to REFRESH_CYCLES, so the first request issues immediately.
- rst mid-clear aborts the sweep; partially cleared contents are retained.

Optional Feature:
- FB_AUTO_REFRESH_EN.
- Defined: update is also issued automatically whenever dirty and the timer is saturated.
- Undefined: only present (including present held pending during CLEAR) causes update. dirty is still maintained, but only internally.

Decomposition:
- Shared package fb_pkg: FB_W, FB_H, COLOR_W, the address width constant (11), the state enum {IDLE, CLEAR}, and the colour-index constants (BLACK=1 ... LIGHT_RED=14) shared with the LCD stage's RGB565 lookup.
- One natural sub-module: fb_ram, a simple dual-port LUT RAM with a synchronous write and an asynchronous read. The FSM, timer and arbitration stay in fb_store.

Test Plan:
1. Reset with present=1 held one cycle after reset release -> update pulses the next cycle; busy=0; wr_ready=1.
2. Write (x=59,y=31,color=7); then rd_x=59,rd_y=31 -> rd_color=7 the next cycle. Write x=60 -> memory unchanged, drop_err=1.
3. clr_req with clr_color=3 -> busy high for exactly 1920 cycles. wr_en mid-clear is dropped and drop_err set. Afterwards every address reads 3.
4. present during CLEAR -> no update while busy. update fires in the cycle busy falls, provided the timer is saturated.
5. Two present pulses 100 cycles apart -> second update delayed until REFRESH_CYCLES after the first.
6. With FB_AUTO_REFRESH_EN: single write, no present -> update once the timer saturates, and no further pulses while idle. Without FB_AUTO_REFRESH_EN: same stimulus -> no update.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, FSM states and colour-index constants
// shared by fb_store, fb_ram and the LCD stage's RGB565 lookup.
package fb_pkg;

  localparam int FB_W    = 60;
  localparam int FB_H    = 32;
  localparam int COLOR_W = 4;
  localparam int FB_AW   = 11;
  localparam int FB_N    = FB_W * FB_H;

  localparam logic [5:0] FB_XLIM = 6'(FB_W);
  localparam logic [5:0] FB_YLIM = 6'(FB_H);

  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_N - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } fb_state_e;

  localparam logic [COLOR_W-1:0] BLACK       = 4'd1;
  localparam logic [COLOR_W-1:0] WHITE       = 4'd2;
  localparam logic [COLOR_W-1:0] RED         = 4'd3;
  localparam logic [COLOR_W-1:0] GREEN       = 4'd4;
  localparam logic [COLOR_W-1:0] BLUE        = 4'd5;
  localparam logic [COLOR_W-1:0] YELLOW      = 4'd6;
  localparam logic [COLOR_W-1:0] CYAN        = 4'd7;
  localparam logic [COLOR_W-1:0] MAGENTA     = 4'd8;
  localparam logic [COLOR_W-1:0] GRAY        = 4'd9;
  localparam logic [COLOR_W-1:0] ORANGE      = 4'd10;
  localparam logic [COLOR_W-1:0] BROWN       = 4'd11;
  localparam logic [COLOR_W-1:0] LIGHT_BLUE  = 4'd12;
  localparam logic [COLOR_W-1:0] LIGHT_GREEN = 4'd13;
  localparam logic [COLOR_W-1:0] LIGHT_RED   = 4'd14;

  // Row-major linear address; callers range-check x/y first.
  function automatic logic [FB_AW-1:0] fb_addr(
    input logic [5:0] x,
    input logic [5:0] y
  );
    return FB_AW'(y) * FB_AW'(FB_W) + FB_AW'(x);
  endfunction

endpackage

// File: rtl/fb_ram.sv
// fb_ram: simple dual-port LUT RAM, synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write), raddr -> rdata (combinational).
module fb_ram #(
  parameter int DEPTH = 1920,
  parameter int AW    = 11,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fb_store.sv
// fb_store: 60x32 colour-index framebuffer with bulk clear, drop flag and
// rate-limited LCD update pulse. Optional macro: FB_AUTO_REFRESH_EN.
// Ports: clk, rst (sync, active-high); wr_en/wr_x/wr_y/wr_color, wr_ready;
// clr_req/clr_color; present; rd_x/rd_y -> rd_color; update, busy, drop_err.
module fb_store
  import fb_pkg::*;
#(
  parameter int REFRESH_CYCLES = 600000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [5:0]         wr_x,
  input  logic [5:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ready,
  input  logic               clr_req,
  input  logic [COLOR_W-1:0] clr_color,
  input  logic               present,
  input  logic [5:0]         rd_x,
  input  logic [5:0]         rd_y,
  output logic [COLOR_W-1:0] rd_color,
  output logic               update,
  output logic               busy,
  output logic               drop_err
);

  localparam logic [19:0] T_SAT = 20'(REFRESH_CYCLES);

  fb_state_e          state_q, state_d;
  logic [FB_AW-1:0]   caddr_q, caddr_d;
  logic [COLOR_W-1:0] ccol_q, ccol_d;
  logic [19:0]        timer_q, timer_d;
  logic               pend_q, pend_d;
  logic               dirty_q, dirty_d;
  logic               drop_q, drop_d;

  logic               wr_ok;
  logic               wr_acc;
  logic               clr_done;
  logic               sat;
  logic               rd_ok;
  logic [FB_AW-1:0]   rd_addr;
  logic [COLOR_W-1:0] ram_rdata;
  logic               ram_we;
  logic [FB_AW-1:0]   ram_waddr;
  logic [COLOR_W-1:0] ram_wdata;

  assign busy     = (state_q == CLEAR);
  assign wr_ready = ~busy;
  assign drop_err = drop_q;

  assign wr_ok  = (wr_x < FB_XLIM) && (wr_y < FB_YLIM);
  assign wr_acc = wr_en & wr_ready & wr_ok;
  assign sat    = (timer_q == T_SAT);

`ifdef FB_AUTO_REFRESH_EN
  assign update = ~busy & sat & (pend_q | dirty_q);
`else
  assign update = ~busy & sat & pend_q;
`endif

  assign rd_ok    = (rd_x < FB_XLIM) && (rd_y < FB_YLIM);
  assign rd_addr  = rd_ok ? fb_addr(rd_x, rd_y) : '0;
  assign rd_color = rd_ok ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      caddr_q <= '0;
      ccol_q  <= '0;
      timer_q <= T_SAT;
      pend_q  <= 1'b0;
      dirty_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
      ccol_q  <= ccol_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      dirty_q <= dirty_d;
      drop_q  <= drop_d;
    end
  end

  // Single RAM write port: the sweep owns it during CLEAR, the CPU otherwise.
  always_comb begin
    state_d   = state_q;
    caddr_d   = caddr_q;
    ccol_d    = ccol_q;
    clr_done  = 1'b0;
    ram_we    = wr_acc;
    ram_waddr = fb_addr(wr_x, wr_y);
    ram_wdata = wr_color;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          caddr_d = '0;
          ccol_d  = clr_color;
        end
      end
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = caddr_q;
        ram_wdata = ccol_q;
        caddr_d   = caddr_q + 1'b1;
        if (caddr_q == FB_LAST) begin
          state_d  = IDLE;
          caddr_d  = '0;
          clr_done = 1'b1;
        end
      end
    endcase
  end

  // New requests in the update cycle win over the clear of pend/dirty.
  always_comb begin
    timer_d = timer_q;
    if (update) begin
      timer_d = '0;
    end else if (!sat) begin
      timer_d = timer_q + 20'd1;
    end
    pend_d  = present | (pend_q & ~update);
    dirty_d = wr_acc | clr_done | (dirty_q & ~update);
    drop_d  = drop_q | (wr_en & ~wr_acc);
  end

  fb_ram #(
    .DEPTH (FB_N),
    .AW    (FB_AW),
    .DW    (COLOR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_fb_store.sv
// tb_fb_store: directed stimulus with an abstract framebuffer model
// checked every cycle, plus hand-computed expectations.
module tb_fb_store;

  localparam int R  = 500;
  localparam int NW = 60;
  localparam int NH = 32;
  localparam int NP = NW * NH;

`ifdef FB_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_x = '0;
  logic [5:0] wr_y = '0;
  logic [3:0] wr_color = '0;
  logic       wr_ready;
  logic       clr_req = 1'b0;
  logic [3:0] clr_color = '0;
  logic       present = 1'b0;
  logic [5:0] rd_x = '0;
  logic [5:0] rd_y = '0;
  logic [3:0] rd_color;
  logic       update;
  logic       busy;
  logic       drop_err;

  int errors = 0;
  int checks = 0;

  fb_store #(.REFRESH_CYCLES(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_color  (wr_color),
    .wr_ready  (wr_ready),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .present   (present),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_color  (rd_color),
    .update    (update),
    .busy      (busy),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: pixel store with known/unknown cells, clear as a 1920-cycle
  // busy window, and update gated by cycles elapsed since the last pulse.
  int m_mem   [NP];
  bit m_known [NP];
  int m_busy  = 0;
  int m_fill  = 0;
  int m_since = 0;
  bit m_pend  = 0;
  bit m_dirty = 0;
  bit m_drop  = 0;

  function automatic bit m_upd();
    return (m_busy == 0) && (m_since >= R) &&
           (m_pend || (AUTO && m_dirty));
  endfunction

  always @(posedge clk) begin
    bit u;
    bit acc;
    int a;
    if (rst) begin
      if (m_busy > 0) begin
        for (int i = 0; i < NP; i++) m_known[i] = 1'b0;
      end
      m_busy  = 0;
      m_pend  = 0;
      m_dirty = 0;
      m_drop  = 0;
      m_since = R;
    end else begin
      u   = m_upd();
      acc = wr_en && (m_busy == 0) && (wr_x < NW) && (wr_y < NH);
      if (u) begin
        m_since = 0;
        m_pend  = 0;
        m_dirty = 0;
      end else if (m_since < R) begin
        m_since++;
      end
      if (present) m_pend = 1;
      if (wr_en && !acc) m_drop = 1;
      if (acc) begin
        a = int'(wr_y) * NW + int'(wr_x);
        m_mem[a]   = int'(wr_color);
        m_known[a] = 1'b1;
        m_dirty    = 1;
      end
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          for (int i = 0; i < NP; i++) begin
            m_mem[i]   = m_fill;
            m_known[i] = 1'b1;
          end
          m_dirty = 1;
        end
      end else if (clr_req) begin
        m_busy = NP;
        m_fill = int'(clr_color);
        for (int i = 0; i < NP; i++) m_known[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int a;
    if (!rst) begin
      chk("update", {31'd0, update}, {31'd0, m_upd()});
      chk("busy", {31'd0, busy}, {31'd0, m_busy > 0});
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, m_busy == 0});
      chk("drop_err", {31'd0, drop_err}, {31'd0, m_drop});
      if (rd_x < NW && rd_y < NH) begin
        a = int'(rd_y) * NW + int'(rd_x);
        if (m_known[a]) chk("rd_color", {28'd0, rd_color}, m_mem[a]);
      end else begin
        chk("rd_oob", {28'd0, rd_color}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input int c);
    wr_en    = 1'b1;
    wr_x     = 6'(x);
    wr_y     = 6'(y);
    wr_color = 4'(c);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int n;
    int ups;
    bit got;

    // 1: reset, then present right after release
    repeat (3) tick();
    rst     = 1'b0;
    present = 1'b1;
    tick();
    present = 1'b0;
    chk("t1_update", {31'd0, update}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_ready", {31'd0, wr_ready}, 32'd1);
    tick();
    chk("t1_one_shot", {31'd0, update}, 32'd0);

    // 2: corner write, dropped out-of-range write, out-of-range reads
    rd_x = 6'd59;
    rd_y = 6'd31;
    wr(59, 31, 7);
    chk("t2_rd_corner", {28'd0, rd_color}, 32'd7);
    chk("t2_no_drop", {31'd0, drop_err}, 32'd0);
    wr(0, 1, 5);
    rd_x = 6'd0;
    rd_y = 6'd1;
    wr(60, 0, 9);
    chk("t2_no_alias", {28'd0, rd_color}, 32'd5);
    chk("t2_drop", {31'd0, drop_err}, 32'd1);
    rd_x = 6'd59;
    rd_y = 6'd31;
    #1;
    chk("t2_still_7", {28'd0, rd_color}, 32'd7);
    rd_x = 6'd60;
    rd_y = 6'd0;
    #1;
    chk("t2_rd_x_oob", {28'd0, rd_color}, 32'd0);
    rd_x = 6'd0;
    rd_y = 6'd32;
    #1;
    chk("t2_rd_y_oob", {28'd0, rd_color}, 32'd0);
    rd_x = 6'd1;
    rd_y = 6'd1;
    tick();

    // 3+4: clear with concurrent write, drops, ignored re-request, present
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t3_drop_rst", {31'd0, drop_err}, 32'd0);
    clr_req   = 1'b1;
    clr_color = 4'd3;
    wr_en     = 1'b1;
    wr_x      = 6'd1;
    wr_y      = 6'd1;
    wr_color  = 4'd9;
    tick();
    clr_req = 1'b0;
    wr_en   = 1'b0;
    n   = 0;
    ups = 0;
    while (busy && n < 5000) begin
      wr_en     = (n == 50);
      wr_x      = 6'd2;
      wr_y      = 6'd2;
      wr_color  = 4'd4;
      present   = (n == 100);
      clr_req   = (n == 200);
      clr_color = (n == 200) ? 4'd5 : 4'd3;
      tick();
      n++;
      if (busy && update) ups++;
    end
    wr_en   = 1'b0;
    present = 1'b0;
    clr_req = 1'b0;
    chk("t3_busy_len", n, 32'd1920);
    chk("t3_drop_mid", {31'd0, drop_err}, 32'd1);
    chk("t4_no_mid_upd", ups, 32'd0);
    chk("t4_upd_at_fall", {31'd0, update}, 32'd1);
    for (int y = 0; y < NH; y++) begin
      for (int x = 0; x < NW; x++) begin
        rd_x = 6'(x);
        rd_y = 6'(y);
        #2;
        if (rd_color !== 4'd3) chk("t3_fill", {28'd0, rd_color}, 32'd3);
        tick();
      end
    end
    chk("t3_fill_last", {28'd0, rd_color}, 32'd3);

    // reset mid-clear aborts the sweep
    clr_req   = 1'b1;
    clr_color = 4'd6;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, wr_ready}, 32'd1);

    // 5: second present is held until the refresh interval expires
    repeat (R + 5) tick();
    present = 1'b1;
    tick();
    present = 1'b0;
    chk("t5_first", {31'd0, update}, 32'd1);
    n   = 0;
    got = 0;
    while (!got && n < 4 * R) begin
      present = (n == 100);
      tick();
      n++;
      if (update) got = 1;
    end
    present = 1'b0;
    chk("t5_gap", n, R + 1);

    // 6: lone write with no present
    wr(3, 3, 1);
    ups = 0;
    repeat (3 * R) begin
      tick();
      if (update) ups++;
    end
    chk("t6_auto_updates", ups, AUTO ? 32'd1 : 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
